// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter.
// Provides the default PC width and reset vector (also used by BranchFormat),
// the FSM state encoding and the next-PC source selector.
package pc_pkg;

    localparam int unsigned PC_WIDTH_DEF     = 8;
    localparam logic [7:0]  RESET_VECTOR_DEF = 8'h00;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALTED   = 2'd3
    } pc_state_t;

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_INC    = 2'd1,
        SEL_BRANCH = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/pc_next_select.sv
// Next-PC selector for the fetch stage.
// Ports:
//   i_sel       source select from the FSM decode (hold / increment / branch)
//   i_pc        current PC
//   i_target    branch target
//   o_pc_next   selected next PC
//   o_pc_plus1  PC+1 modulo 2^PC_WIDTH (carry discarded)
module pc_next_select
    import pc_pkg::*;
#(
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEF
) (
    input  pc_sel_t             i_sel,
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic [PC_WIDTH-1:0] i_target,
    output logic [PC_WIDTH-1:0] o_pc_next,
    output logic [PC_WIDTH-1:0] o_pc_plus1
);

    logic [PC_WIDTH-1:0] w_pc_plus1;

    // Same-width sum: FF+1 wraps to 00 without a carry out.
    assign w_pc_plus1 = i_pc + PC_WIDTH'(1);
    assign o_pc_plus1 = w_pc_plus1;

    always_comb begin
        o_pc_next = i_pc;
        case (i_sel)
            SEL_INC:    o_pc_next = w_pc_plus1;
            SEL_BRANCH: o_pc_next = i_target;
            default:    o_pc_next = i_pc;
        endcase
    end

endmodule

// File: rtl/program_counter_unit.sv
// Fetch-stage program counter with branch redirect, stall, one-bubble flush
// and HALT/resume control.
// Ports:
//   Clock, ResetN    rising-edge clock, asynchronous active-low reset
//   Stall            decode hazard, hold PC
//   BranchTaken      branch resolved taken; BranchTarget is the new PC
//   Halt, Resume     enter / leave the HALTED state
//   PC, PCPlus1      fetch address and its link value (PCPlus1 combinational)
//   FetchValid       instruction at PC is valid for decode
//   Flush            kill the instruction currently in decode
//   Halted           FSM is in HALTED
//   FetchCount       valid fetches retired since reset
module program_counter_unit
    import pc_pkg::*;
#(
    parameter int unsigned             PC_WIDTH     = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0]     RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF),
    parameter int unsigned             COUNT_WIDTH  = 32
) (
    input  logic                   Clock,
    input  logic                   ResetN,
    input  logic                   Stall,
    input  logic                   BranchTaken,
    input  logic [PC_WIDTH-1:0]    BranchTarget,
    input  logic                   Halt,
    input  logic                   Resume,
    output logic [PC_WIDTH-1:0]    PC,
    output logic [PC_WIDTH-1:0]    PCPlus1,
    output logic                   FetchValid,
    output logic                   Flush,
    output logic                   Halted,
    output logic [COUNT_WIDTH-1:0] FetchCount
);

    pc_state_t r_state;
    pc_state_t w_state_nxt;

    logic [PC_WIDTH-1:0]    r_pc;
    logic                   r_fetch_valid;
    logic                   r_flush;
    logic                   r_halted;
    logic [COUNT_WIDTH-1:0] r_fetch_count;

    pc_sel_t                w_sel;
    logic [PC_WIDTH-1:0]    w_pc_next;
    logic [PC_WIDTH-1:0]    w_pc_plus1;
    logic                   w_fv_nxt;
    logic                   w_flush_nxt;
    logic                   w_halted_nxt;
    logic                   w_count_en;

    pc_next_select #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_select (
        .i_sel      (w_sel),
        .i_pc       (r_pc),
        .i_target   (BranchTarget),
        .o_pc_next  (w_pc_next),
        .o_pc_plus1 (w_pc_plus1)
    );

    // State register
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: BranchTaken > Halt in RUN; Resume alone leaves HALTED
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (BranchTaken)  w_state_nxt = ST_REDIRECT;
                else if (Halt)    w_state_nxt = ST_HALTED;
                else              w_state_nxt = ST_RUN;
            end
            ST_REDIRECT: begin
                if (BranchTaken)  w_state_nxt = ST_REDIRECT;
                else              w_state_nxt = ST_RUN;
            end
            ST_HALTED: begin
                if (Resume)       w_state_nxt = ST_RUN;
                else              w_state_nxt = ST_HALTED;
            end
        endcase
    end

    // Output decode: next values for the registered outputs and PC source
    always_comb begin
        w_sel        = SEL_HOLD;
        w_fv_nxt     = r_fetch_valid;
        w_flush_nxt  = 1'b0;
        w_halted_nxt = r_halted;
        w_count_en   = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_fv_nxt     = 1'b1;
                w_halted_nxt = 1'b0;
            end
            ST_RUN: begin
                if (BranchTaken) begin
                    w_sel       = SEL_BRANCH;
                    w_flush_nxt = 1'b1;
                    w_fv_nxt    = 1'b0;
                end else if (Halt) begin
                    w_fv_nxt     = 1'b0;
                    w_halted_nxt = 1'b1;
                end else if (Stall) begin
                    w_sel = SEL_HOLD;
                end else begin
                    w_sel      = SEL_INC;
                    w_count_en = r_fetch_valid;
                end
            end
            ST_REDIRECT: begin
                if (BranchTaken) begin
                    w_sel       = SEL_BRANCH;
                    w_flush_nxt = 1'b1;
                    w_fv_nxt    = 1'b0;
                end else begin
                    w_fv_nxt = 1'b1;
                end
            end
            ST_HALTED: begin
                // PC is frozen here; the resume cycle does not increment it
                if (Resume) begin
                    w_fv_nxt     = 1'b1;
                    w_halted_nxt = 1'b0;
                end else begin
                    w_fv_nxt = 1'b0;
                end
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_pc          <= RESET_VECTOR;
            r_fetch_valid <= 1'b0;
            r_flush       <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_pc          <= w_pc_next;
            r_fetch_valid <= w_fv_nxt;
            r_flush       <= w_flush_nxt;
            r_halted      <= w_halted_nxt;
            if (w_count_en) begin
                r_fetch_count <= r_fetch_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign PC         = r_pc;
    assign PCPlus1    = w_pc_plus1;
    assign FetchValid = r_fetch_valid;
    assign Flush      = r_flush;
    assign Halted     = r_halted;
    assign FetchCount = r_fetch_count;

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed self-checking bench for program_counter_unit.
module tb_program_counter_unit;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic        Stall;
    logic        BranchTaken;
    logic [7:0]  BranchTarget;
    logic        Halt;
    logic        Resume;
    logic [7:0]  PC;
    logic [7:0]  PCPlus1;
    logic        FetchValid;
    logic        Flush;
    logic        Halted;
    logic [31:0] FetchCount;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    program_counter_unit #(
        .PC_WIDTH     (8),
        .RESET_VECTOR (8'h00),
        .COUNT_WIDTH  (32)
    ) dut (
        .Clock        (Clock),
        .ResetN       (ResetN),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Halt         (Halt),
        .Resume       (Resume),
        .PC           (PC),
        .PCPlus1      (PCPlus1),
        .FetchValid   (FetchValid),
        .Flush        (Flush),
        .Halted       (Halted),
        .FetchCount   (FetchCount)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [7:0] pc, input logic fv,
                                input logic fl, input logic hl, input logic [31:0] cnt);
        check({tag, " PC"}, 32'(PC), 32'(pc));
        check({tag, " FetchValid"}, 32'(FetchValid), 32'(fv));
        check({tag, " Flush"}, 32'(Flush), 32'(fl));
        check({tag, " Halted"}, 32'(Halted), 32'(hl));
        check({tag, " FetchCount"}, FetchCount, cnt);
    endtask

    initial begin
        ResetN = 1'b0; Stall = 1'b0; BranchTaken = 1'b0;
        BranchTarget = 8'h00; Halt = 1'b0; Resume = 1'b0;
        #12;
        expect_state("reset", 8'h00, 1'b0, 1'b0, 1'b0, 32'd0);
        check("reset PCPlus1", 32'(PCPlus1), 32'h01);

        // Release reset: one BOOT cycle, then incrementing
        @(negedge Clock); ResetN = 1'b1;
        #1 expect_state("boot", 8'h00, 1'b0, 1'b0, 1'b0, 32'd0);
        tick(); expect_state("run0", 8'h00, 1'b1, 1'b0, 1'b0, 32'd0);
        tick(); expect_state("run1", 8'h01, 1'b1, 1'b0, 1'b0, 32'd1);
        tick(); expect_state("run2", 8'h02, 1'b1, 1'b0, 1'b0, 32'd2);
        tick(); expect_state("run3", 8'h03, 1'b1, 1'b0, 1'b0, 32'd3);
        tick(); expect_state("run4", 8'h04, 1'b1, 1'b0, 1'b0, 32'd4);
        check("run4 PCPlus1", 32'(PCPlus1), 32'h05);
        tick(); expect_state("run5", 8'h05, 1'b1, 1'b0, 1'b0, 32'd5);

        // Stall held three cycles at 05
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_state("stall", 8'h05, 1'b1, 1'b0, 1'b0, 32'd5);
        end
        Stall = 1'b0;
        tick(); expect_state("unstall", 8'h06, 1'b1, 1'b0, 1'b0, 32'd6);

        // Get to PC=10 via a branch
        BranchTaken = 1'b1; BranchTarget = 8'h10;
        tick(); expect_state("br10", 8'h10, 1'b0, 1'b1, 1'b0, 32'd6);
        BranchTaken = 1'b0;
        tick(); expect_state("br10 bubble", 8'h10, 1'b1, 1'b0, 1'b0, 32'd6);

        // Branch with simultaneous Stall: branch wins
        BranchTaken = 1'b1; BranchTarget = 8'h40; Stall = 1'b1;
        tick(); expect_state("br40", 8'h40, 1'b0, 1'b1, 1'b0, 32'd6);
        BranchTaken = 1'b0; Stall = 1'b0;
        tick(); expect_state("br40 bubble", 8'h40, 1'b1, 1'b0, 1'b0, 32'd6);
        tick(); expect_state("br40 next", 8'h41, 1'b1, 1'b0, 1'b0, 32'd7);

        // Wrap-around through FF
        BranchTaken = 1'b1; BranchTarget = 8'hFE;
        tick(); expect_state("brFE", 8'hFE, 1'b0, 1'b1, 1'b0, 32'd7);
        BranchTaken = 1'b0;
        tick(); expect_state("FE", 8'hFE, 1'b1, 1'b0, 1'b0, 32'd7);
        tick(); expect_state("FF", 8'hFF, 1'b1, 1'b0, 1'b0, 32'd8);
        check("FF PCPlus1", 32'(PCPlus1), 32'h00);
        tick(); expect_state("wrap00", 8'h00, 1'b1, 1'b0, 1'b0, 32'd9);

        // Back-to-back branch while in REDIRECT
        BranchTaken = 1'b1; BranchTarget = 8'h30;
        tick(); expect_state("br30", 8'h30, 1'b0, 1'b1, 1'b0, 32'd9);
        BranchTarget = 8'h22;
        tick(); expect_state("br22 rd", 8'h22, 1'b0, 1'b1, 1'b0, 32'd9);
        BranchTaken = 1'b0;
        tick(); expect_state("br22 bubble", 8'h22, 1'b1, 1'b0, 1'b0, 32'd9);

        // Halt at 22; branch/stall ignored while halted
        Halt = 1'b1;
        tick(); expect_state("halt", 8'h22, 1'b0, 1'b0, 1'b1, 32'd9);
        Halt = 1'b0; BranchTaken = 1'b1; BranchTarget = 8'h80; Stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(); expect_state("halted", 8'h22, 1'b0, 1'b0, 1'b1, 32'd9);
        end
        BranchTaken = 1'b0; Stall = 1'b0;
        Halt = 1'b1; Resume = 1'b1;
        tick(); expect_state("resume", 8'h22, 1'b1, 1'b0, 1'b0, 32'd9);
        Halt = 1'b0; Resume = 1'b0;
        tick(); expect_state("after resume", 8'h23, 1'b1, 1'b0, 1'b0, 32'd10);

        // Asynchronous reset in the middle of REDIRECT
        BranchTaken = 1'b1; BranchTarget = 8'h77;
        tick(); expect_state("br77", 8'h77, 1'b0, 1'b1, 1'b0, 32'd10);
        BranchTaken = 1'b0;
        #2 ResetN = 1'b0;
        #1 expect_state("async rst", 8'h00, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge Clock); ResetN = 1'b1;
        #1 expect_state("reboot", 8'h00, 1'b0, 1'b0, 1'b0, 32'd0);
        tick(); expect_state("rerun0", 8'h00, 1'b1, 1'b0, 1'b0, 32'd0);
        tick(); expect_state("rerun1", 8'h01, 1'b1, 1'b0, 1'b0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_counter_unit.md
Name: program_counter_unit

Overview:
- Fetch-stage program counter. Holds the 8-bit PC that addresses instruction memory and advances it by one each cycle.
- Consumes BranchTarget from BranchFormat and redirects the PC when a branch resolves taken.
- Handles pipeline stall, a one-bubble flush after a redirect, and a HALT/resume state machine.
- Drives PC and PCPlus1 (link value) to instruction memory and the decode stage.

Parameters:
- PC_WIDTH, 8, width of PC, BranchTarget and PCPlus1.
- RESET_VECTOR, 8'h00, PC value loaded on reset.
- COUNT_WIDTH, 32, width of the retired-fetch counter.

Ports:
- Clock  in  1  system clock, rising edge.
- ResetN  in  1  asynchronous active-low reset.
- Stall  in  1  decode hazard; hold PC.
- BranchTaken  in  1  branch resolved taken this cycle.
- BranchTarget  in  PC_WIDTH  target from BranchFormat.
- Halt  in  1  decoded HALT instruction.
- Resume  in  1  external restart request.
- PC  out  PC_WIDTH  current fetch address.
- PCPlus1  out  PC_WIDTH  PC+1 modulo 2^PC_WIDTH, combinational from PC.
- FetchValid  out  1  instruction at PC is valid for decode.
- Flush  out  1  kill the instruction currently in decode.
- Halted  out  1  FSM is in HALTED.
- FetchCount  out  COUNT_WIDTH  number of valid fetches since reset.

Behaviour:
- Reset (ResetN=0, asynchronous, any state, mid-operation included):
  - PC=RESET_VECTOR; state=BOOT.
  - FetchValid=0, Flush=0, Halted=0, FetchCount=0.
- States: BOOT, RUN, REDIRECT, HALTED. All outputs are registered except PCPlus1.
- BOOT:
  - Lasts exactly one cycle after reset release. FetchValid=0 and PC holds.
  - Next state is RUN.
- RUN, priority per cycle is BranchTaken > Halt > Stall > increment:
  - BranchTaken=1: PC<=BranchTarget, Flush<=1, FetchValid<=0, next REDIRECT. This overrides Stall and Halt.
  - Halt=1: PC holds, FetchValid<=0, Halted<=1, next HALTED.
  - Stall=1: PC holds, FetchValid stays 1, FetchCount unchanged.
  - Otherwise: PC<=PC+1 and FetchCount+=1. 8'hFF wraps to 8'h00 with no flag.
- REDIRECT:
  - Exactly one bubble cycle. Flush<=0, PC holds the target, next RUN with FetchValid<=1.
  - A second BranchTaken in REDIRECT is honoured: PC<=new target, Flush<=1 again, stay in REDIRECT.
- HALTED:
  - PC frozen; BranchTaken and Stall are ignored.
  - Resume=1: FetchValid<=1, Halted<=0, next RUN. The PC is not incremented on the resume cycle.
  - Halt and Resume both high while in HALTED: Resume wins.
- FetchCount:
  - Increments on every RUN cycle with FetchValid=1, Stall=0, BranchTaken=0, Halt=0.
  - Wraps modulo 2^COUNT_WIDTH.
- Latency:
  - Redirect: BranchTaken at edge N gives PC=target after edge N. First valid fetch of the target is after edge N+1.
  - A taken branch costs one bubble.
- Unknown-free: PCPlus1 is computed as a PC_WIDTH-bit sum. The carry is discarded.

Decomposition:
- Shared package pc_pkg:
  - State encoding constants ST_BOOT=2'd0, ST_RUN=2'd1, ST_REDIRECT=2'd2, ST_HALTED=2'd3.
  - PC_WIDTH default and RESET_VECTOR default, shared with BranchFormat.
- One natural sub-module: pc_next_select. It is combinational and picks the next PC from hold, PC+1 and BranchTarget using the FSM decode.
- FSM and registers stay in the top module.

Test Plan:
- Reset then run 5 cycles, no stall:
  - PC sequence 00 (BOOT), 00, 01, 02, 03, 04. FetchValid 0 then 1.
  - FetchCount=4 after the last edge.
- Wrap-around: branch to 8'hFE, then run 3 cycles → PC FE, FF, 00. No other flags.
- Branch in RUN at PC=8'h10 with BranchTarget=8'h40 and Stall=1 in the same cycle:
  - Next PC=40, Flush=1 for one cycle, FetchValid=0 for one cycle.
  - Then PC=41 one cycle after valid resumes.
- Stall held 3 cycles at PC=8'h05 → PC stays 05, FetchValid=1, FetchCount unchanged. Release → PC=06.
- Halt at PC=8'h22:
  - Halted=1 and PC stays 22 for 10 cycles, ignoring BranchTaken=1 with target 8'h80.
  - Resume=1 → Halted=0, FetchValid=1, PC=22, then 23.
- Assert ResetN=0 mid-REDIRECT (target 8'h77):
  - PC immediately returns to 00 without waiting for a clock edge.
  - Flush, FetchValid and FetchCount clear; BOOT repeats after release.
